// File: rtl/fixed_mac_acc_if.sv
// Operand stream in, saturated row result out, for the fixed-point MAC stage.
interface fixed_mac_acc_if #(
  parameter int DATA_WIDTH = 18,
  parameter int OUT_WIDTH  = 18
);
  logic signed [DATA_WIDTH-1:0] a_in;
  logic signed [DATA_WIDTH-1:0] b_in;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic signed [OUT_WIDTH-1:0]  acc_out;
  logic                         out_valid;
  logic                         out_ready;
  logic                         sat_flag;

  // Upstream/downstream side: drives operands and out_ready.
  modport master (
    output a_in, b_in, in_valid, in_last, out_ready,
    input  in_ready, acc_out, out_valid, sat_flag
  );

  // MAC stage side.
  modport slave (
    input  a_in, b_in, in_valid, in_last, out_ready,
    output in_ready, acc_out, out_valid, sat_flag
  );
endinterface

// File: rtl/fixed_mac_acc.sv
// Signed fixed-point multiply-accumulate: one product per beat, summed over a
// row delimited by in_last, then rescaled by FRAC_BITS and saturated.
// Two register stages (product, accumulate/output) share one advance enable,
// so a stalled result freezes the whole pipe.
module fixed_mac_acc #(
  parameter int DATA_WIDTH = 18,
  parameter int FRAC_BITS  = 8,
  parameter int GUARD_BITS = 8,
  parameter int OUT_WIDTH  = 18
) (
  input logic            clk,
  input logic            rst,
  fixed_mac_acc_if.slave bus
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + GUARD_BITS;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  logic                         en;
  logic                         xfer;

  logic signed [PROD_WIDTH-1:0] p_r;
  logic                         p_valid;
  logic                         p_last;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         first;

  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH-1:0]  scaled;
  logic signed [ACC_WIDTH-1:0]  clipped;
  logic                         clip_hit;
  logic                         acc_step;
  logic                         new_result;

  logic signed [OUT_WIDTH-1:0]  acc_out_r;
  logic                         out_valid_r;
  logic                         sat_r;

  // Advance whenever there is no unconsumed result blocking the output.
  assign en            = !out_valid_r || bus.out_ready;
  assign xfer          = bus.in_valid && en;
  assign acc_step      = en && p_valid;
  assign new_result    = acc_step && p_last;

  assign bus.in_ready  = en;
  assign bus.acc_out   = acc_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sat_flag  = sat_r;

  // Product register: captures a*b on every advance; the valid/last tags
  // record whether a real beat entered so idle cycles leave acc untouched.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values of the others, regardless of statement order.
    if (rst) begin
      p_r     <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      p_r     <= bus.a_in * bus.b_in;
      p_valid <= xfer;
      p_last  <= bus.in_last && xfer;
    end
  end

  // Accumulate, rescale (floor shift) and clip to the output range.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    acc_base = '0;
    clip_hit = 1'b0;
    if (!first) acc_base = acc;
    acc_next = acc_base + {{GUARD_BITS{p_r[PROD_WIDTH-1]}}, p_r};
    scaled   = acc_next >>> FRAC_BITS;
    clipped  = scaled;
    if (scaled > OUT_MAX) begin
      clipped  = OUT_MAX;
      clip_hit = 1'b1;
    end else if (scaled < OUT_MIN) begin
      clipped  = OUT_MIN;
      clip_hit = 1'b1;
    end
  end

  // Accumulator and result register; a new result overrides a consumed one,
  // otherwise a consumed result just drops valid and keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      first       <= 1'b1;
      acc_out_r   <= '0;
      out_valid_r <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      if (acc_step) begin
        acc   <= acc_next;
        first <= p_last;
      end
      if (new_result) begin
        acc_out_r   <= clipped[OUT_WIDTH-1:0];
        out_valid_r <= 1'b1;
        if (clip_hit) sat_r <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule
